// File: rtl/el2_lsu_trigger_ctl.sv
// LSU trigger controller: qualifies and chains per-trigger M-stage matches,
// raises one action request to decode, and tracks sticky hit/drop status.
module el2_lsu_trigger_ctl #(
   parameter int NTRIG = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NTRIG-1:0] lsu_trigger_match_m,
   input  logic             lsu_flush_m,
   input  logic [NTRIG-1:0] trig_enable,
   input  logic [NTRIG-1:0] trig_chain,
   input  logic [NTRIG-1:0] trig_action,
   input  logic             dbg_mode,
   input  logic             trig_ack,
   input  logic [NTRIG-1:0] hit_clr,
   output logic             trig_req,
   output logic             trig_req_halt,
   output logic [NTRIG-1:0] trig_req_mask,
   output logic [NTRIG-1:0] trig_hit,
   output logic             trig_drop
);

   // state    | meaning
   // IDLE     | no request outstanding, matches are captured
   // REQ      | request presented to decode, waiting for trig_ack
   // WAIT_DBG | halt accepted, waiting for dbg_mode to rise then fall
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_DBG = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [NTRIG-1:0]   qual;
   logic [NTRIG-1:0]   eff;
   logic [NTRIG/2-1:0] chain_odd;
   logic               unused_chain_odd;
   logic               any_eff;
   logic               capture;
   logic               ack_take;
   logic               busy_match;
   logic               dbg_seen;

   assign qual = lsu_trigger_match_m & trig_enable & {NTRIG{~lsu_flush_m & ~dbg_mode}};

   // A chained pair fires only when both halves match in the same cycle.
   for (genvar k = 0; k < NTRIG/2; k++) begin : g_pair
      logic both;
      assign both         = qual[2*k] & qual[2*k+1];
      assign eff[2*k]     = trig_chain[2*k] ? both : qual[2*k];
      assign eff[2*k+1]   = trig_chain[2*k] ? both : qual[2*k+1];
      assign chain_odd[k] = trig_chain[2*k+1];
   end

   assign unused_chain_odd = ^chain_odd;

   assign any_eff    = |eff;
   assign busy_match = any_eff & (state != IDLE);
   assign ack_take   = (state == REQ) & trig_ack;

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (any_eff) begin
               state_nxt = REQ;
               capture   = 1'b1;
            end
         end
         REQ: begin
            if (trig_ack) begin
               state_nxt = trig_req_halt ? WAIT_DBG : IDLE;
            end
         end
         WAIT_DBG: begin
            if (dbg_seen & ~dbg_mode) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         trig_req_mask <= '0;
         trig_req_halt <= 1'b0;
         trig_hit      <= '0;
         trig_drop     <= 1'b0;
         dbg_seen      <= 1'b0;
      end else begin
         state <= state_nxt;

         if (capture) begin
            trig_req_mask <= eff;
            trig_req_halt <= |(eff & trig_action);
         end else if (state_nxt == IDLE) begin
            trig_req_mask <= '0;
            trig_req_halt <= 1'b0;
         end

         // Set wins over a coincident CSR clear.
         trig_hit <= (trig_hit & ~hit_clr) | (ack_take ? trig_req_mask : '0);

         if (busy_match) begin
            trig_drop <= 1'b1;
         end

         // dbg_mode already high on the first WAIT_DBG cycle counts as the rise.
         if (state != WAIT_DBG) begin
            dbg_seen <= 1'b0;
         end else if (dbg_mode) begin
            dbg_seen <= 1'b1;
         end
      end
   end

   assign trig_req = (state == REQ);

endmodule

// File: tb/tb_el2_lsu_trigger_ctl.sv
// Directed bench for el2_lsu_trigger_ctl with a cycle-level reference model
// checked every negative clock edge, plus literal spot checks.
module tb_el2_lsu_trigger_ctl;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] match, enable, chain, action, hit_clr;
   logic         flush, dbg, ack;
   logic         trig_req, trig_req_halt, trig_drop;
   logic [N-1:0] trig_req_mask, trig_hit;

   int tests = 0;
   int fails = 0;

   el2_lsu_trigger_ctl #(.NTRIG(N)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .lsu_trigger_match_m (match),
      .lsu_flush_m         (flush),
      .trig_enable         (enable),
      .trig_chain          (chain),
      .trig_action         (action),
      .dbg_mode            (dbg),
      .trig_ack            (ack),
      .hit_clr             (hit_clr),
      .trig_req            (trig_req),
      .trig_req_halt       (trig_req_halt),
      .trig_req_mask       (trig_req_mask),
      .trig_hit            (trig_hit),
      .trig_drop           (trig_drop)
   );

   always #5 clk = ~clk;

   // Reference model: a pending request record plus a "waiting for debug" flag.
   bit           m_pending, m_waiting, m_risen, m_drop, m_halt;
   bit [N-1:0]   m_mask, m_hit;

   always @(posedge clk or posedge rst) begin
      bit [N-1:0] q, e, nh;
      if (rst) begin
         m_pending = 0; m_waiting = 0; m_risen = 0; m_drop = 0;
         m_halt = 0; m_mask = '0; m_hit = '0;
      end else begin
         q = (flush || dbg) ? '0 : (match & enable);
         e = q;
         for (int p = 0; p < N; p += 2)
            if (chain[p]) begin
               e[p]   = q[p] && q[p+1];
               e[p+1] = q[p] && q[p+1];
            end
         nh = m_hit & ~hit_clr;
         if (!m_pending && !m_waiting) begin
            if (e != 0) begin
               m_pending = 1; m_mask = e; m_halt = (e & action) != 0;
            end
         end else begin
            if (e != 0) m_drop = 1;
            if (m_pending) begin
               if (ack) begin
                  nh = nh | m_mask;
                  m_pending = 0;
                  if (m_halt) begin
                     m_waiting = 1; m_risen = 0;
                  end else begin
                     m_mask = '0; m_halt = 0;
                  end
               end
            end else if (m_risen && !dbg) begin
               m_waiting = 0; m_mask = '0; m_halt = 0;
            end else if (dbg) begin
               m_risen = 1;
            end
         end
         m_hit = nh;
      end
   end

   always @(negedge clk) begin
      tests++;
      if (trig_req !== m_pending || trig_req_halt !== m_halt || trig_req_mask !== m_mask ||
          trig_hit !== m_hit || trig_drop !== m_drop) begin
         fails++;
         $display("FAIL model t=%0t req=%b/%b halt=%b/%b mask=%b/%b hit=%b/%b drop=%b/%b (got/exp)",
                  $time, trig_req, m_pending, trig_req_halt, m_halt, trig_req_mask, m_mask,
                  trig_hit, m_hit, trig_drop, m_drop);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1; match = '0; enable = 4'hF; chain = '0; action = '0; hit_clr = '0;
      flush = 0; dbg = 0; ack = 0;
      tick(); tick();
      chk("reset_req", {31'b0, trig_req}, 0);
      chk("reset_hit", {28'b0, trig_hit}, 0);
      rst = 0;
      tick();

      // Basic breakpoint request acked in its third cycle.
      match = 4'b0100; tick(); match = '0;
      chk("b_req_c1", {31'b0, trig_req}, 1);
      chk("b_mask", {28'b0, trig_req_mask}, 4'b0100);
      chk("b_halt", {31'b0, trig_req_halt}, 0);
      tick();
      chk("b_req_c2", {31'b0, trig_req}, 1);
      tick(); ack = 1;
      chk("b_req_c3", {31'b0, trig_req}, 1);
      tick(); ack = 0;
      chk("b_req_c4", {31'b0, trig_req}, 0);
      chk("b_hit_c4", {28'b0, trig_hit}, 4'b0100);
      chk("b_mask_idle", {28'b0, trig_req_mask}, 0);

      // Chained pair 0/1: one half alone is not enough.
      chain = 4'b0001; match = 4'b0001; tick(); match = '0;
      chk("ch_half", {31'b0, trig_req}, 0);
      match = 4'b0011; tick(); match = '0;
      chk("ch_both_req", {31'b0, trig_req}, 1);
      chk("ch_both_mask", {28'b0, trig_req_mask}, 4'b0011);
      ack = 1; tick(); ack = 0;
      chk("ch_hit", {28'b0, trig_hit}, 4'b0111);
      hit_clr = 4'hF; tick(); hit_clr = '0;
      chk("hit_cleared", {28'b0, trig_hit}, 0);
      chain = '0;

      // Halt action: wait for debug entry and exit.
      action = 4'b1000; match = 4'b1000; tick(); match = '0;
      chk("h_halt", {31'b0, trig_req_halt}, 1);
      ack = 1; tick(); ack = 0;
      chk("h_wait_req", {31'b0, trig_req}, 0);
      tick(); tick();
      dbg = 1; match = 4'b1000; tick(); match = '0; tick();
      chk("h_dbg_req", {31'b0, trig_req}, 0);
      chk("h_dbg_drop", {31'b0, trig_drop}, 0);
      dbg = 0; tick();
      chk("h_idle_mask", {28'b0, trig_req_mask}, 0);
      match = 4'b0001; tick(); match = '0;
      chk("h_after_req", {31'b0, trig_req}, 1);
      chk("h_after_halt", {31'b0, trig_req_halt}, 0);
      ack = 1; tick(); ack = 0;
      chk("h_hit", {28'b0, trig_hit}, 4'b1001);

      // Busy-match while REQ is held unacked; ack coincides with hit_clr[2].
      match = 4'b0100; tick(); match = '0;
      match = 4'b0010; tick(); match = '0; tick();
      chk("busy_drop", {31'b0, trig_drop}, 1);
      chk("busy_mask", {28'b0, trig_req_mask}, 4'b0100);
      chk("busy_req", {31'b0, trig_req}, 1);
      hit_clr = 4'b0100; ack = 1; tick(); hit_clr = '0; ack = 0;
      chk("set_wins", {28'b0, trig_hit}, 4'b1101);

      // Flushed match is not qualified.
      flush = 1; match = 4'hF; tick(); flush = 0; match = '0;
      chk("flush_req", {31'b0, trig_req}, 0);

      // Asynchronous reset in the middle of a request.
      match = 4'b0001; tick(); match = '0;
      chk("pre_rst_req", {31'b0, trig_req}, 1);
      #1 rst = 1; #1;
      chk("async_req", {31'b0, trig_req}, 0);
      chk("async_mask", {28'b0, trig_req_mask}, 0);
      chk("async_halt", {31'b0, trig_req_halt}, 0);
      chk("async_hit", {28'b0, trig_hit}, 0);
      chk("async_drop", {31'b0, trig_drop}, 0);
      tick(); rst = 0;
      match = 4'b0010; tick(); match = '0;
      chk("post_rst_req", {31'b0, trig_req}, 1);
      chk("post_rst_mask", {28'b0, trig_req_mask}, 4'b0010);
      chk("post_rst_hit", {28'b0, trig_hit}, 0);
      ack = 1; tick(); ack = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
